hilo_mdu: RTL and testbench

Parametrised HI/LO register file with an integrated multiply/divide unit; successor to the plain HI/LO register pair. Sits beside the EX stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, runs multiplies over a configurable pipeline and divides iteratively, and raises a stall request while busy. HI/LO are written only on operation completion, so MFHI/MFLO read the committed value.

---
 rtl/hilo_mdu_pkg.sv | 22 ++
 rtl/hilo_mdu_div_iter.sv | 77 +++++++
 rtl/hilo_mdu.sv | 133 +++++++++++++
 tb/tb_hilo_mdu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared op codes, FSM state encodings and helpers for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

  localparam logic [2:0] MDU_OP_NOP   = 3'd0;
  localparam logic [2:0] MDU_OP_MULT  = 3'd1;
  localparam logic [2:0] MDU_OP_MULTU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd3;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Ops that occupy the unit for more than the accept cycle.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Radix-2 restoring divider on magnitudes; one quotient bit per cycle, signs applied on output.
module hilo_mdu_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_busy;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // r_quo starts as the dividend and shifts quotient bits in from the bottom.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_fits    = ~w_diff[WIDTH];
    w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
  end

  assign o_finished  = r_busy & (r_cnt == CntW'(WIDTH - 1));
  assign o_quotient  = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign o_remainder = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= i_dividend;
      r_dvs   <= i_divisor;
      r_neg_q <= i_neg_q;
      r_neg_r <= i_neg_r;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (o_finished) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register pair with a pipelined multiplier and iterative divider; HI/LO commit on completion.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] hi_rdata,
  output logic [WIDTH-1:0] lo_rdata
);

  localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  logic [1:0]         r_state;
  logic [MulCntW-1:0] r_mul_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_pipe [MUL_STAGES];

  logic               w_accept;
  logic               w_signed;
  logic               w_mul_go;
  logic               w_div_go;
  logic               w_mul_last;
  logic               w_div_last;
  logic               w_div_fin;
  logic signed [WIDTH:0] w_ma;
  logic signed [WIDTH:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_accept   = op_valid & ~flush & (r_state == ST_IDLE);
    w_signed   = (op == MDU_OP_MULT) | (op == MDU_OP_DIV);
    w_mul_go   = w_accept & ((op == MDU_OP_MULT) | (op == MDU_OP_MULTU));
    w_div_go   = w_accept & ((op == MDU_OP_DIV) | (op == MDU_OP_DIVU)) & (src_b != '0);
    w_mul_last = (r_state == ST_MUL) & (r_mul_cnt == MulCntW'(MUL_STAGES - 1));
    w_div_last = (r_state == ST_DIV) & w_div_fin;
    // One extra bit lets a single signed multiply serve both MULT and MULTU.
    w_ma       = {w_signed & src_a[WIDTH-1], src_a};
    w_mb       = {w_signed & src_b[WIDTH-1], src_b};
    w_prod     = (2*WIDTH)'(w_ma) * (2*WIDTH)'(w_mb);
    w_neg_a    = w_signed & src_a[WIDTH-1];
    w_neg_b    = w_signed & src_b[WIDTH-1];
    w_mag_a    = w_neg_a ? (~src_a + 1'b1) : src_a;
    w_mag_b    = w_neg_b ? (~src_b + 1'b1) : src_b;
  end

  assign stallreq = (r_state != ST_IDLE) | (op_valid & is_long_op(op) & ~flush);
  assign done     = (w_mul_last | w_div_last) & ~flush;
  assign hi_rdata = r_hi;
  assign lo_rdata = r_lo;

  hilo_mdu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_div_go),
    .i_flush     (flush),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .i_neg_q     (w_neg_a ^ w_neg_b),
    .i_neg_r     (w_neg_a),
    .o_finished  (w_div_fin),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_mul_cnt <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_mul_cnt <= '0;
          if (w_mul_go) r_state <= ST_MUL;
          else if (w_div_go) r_state <= ST_DIV;
        end
        ST_MUL: begin
          if (w_mul_last) r_state <= ST_IDLE;
          else r_mul_cnt <= r_mul_cnt + 1'b1;
        end
        ST_DIV: if (w_div_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(MUL_STAGES); i++) r_pipe[i] <= '0;
    end else begin
      if (w_mul_go) r_pipe[0] <= w_prod;
      for (int i = 1; i < int'(MUL_STAGES); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (done && w_mul_last) begin
      r_hi <= r_pipe[MUL_STAGES-1][2*WIDTH-1:WIDTH];
      r_lo <= r_pipe[MUL_STAGES-1][WIDTH-1:0];
    end else if (done && w_div_last) begin
      r_hi <= w_rem;
      r_lo <= w_quo;
    end else if (w_accept && op == MDU_OP_MTHI) begin
      r_hi <= src_a;
    end else if (w_accept && op == MDU_OP_MTLO) begin
      r_lo <= src_a;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomised self-checking bench for hilo_mdu against an arithmetic HI/LO reference model.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MS = 2;

  logic          clk;
  logic          resetn;
  logic          op_valid;
  logic [2:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          flush;
  logic          stallreq;
  logic          done;
  logic [W-1:0]  hi_rdata;
  logic [W-1:0]  lo_rdata;

  int n_vec;
  int n_err;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  hilo_mdu #(
    .WIDTH      (W),
    .MUL_STAGES (MS)
  ) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stallreq (stallreq),
    .done     (done),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one op from a negedge; counts stall and done cycles until stallreq drops.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int flush_at, input bit junk, output int stalls, output int dones);
    bit ended;
    stalls = 0;
    dones  = 0;
    ended  = 1'b0;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = (flush_at == 0);
    #1;
    if (stallreq) stalls++;
    if (done) dones++;
    @(negedge clk);
    op_valid = 1'b0; op = MDU_OP_NOP; flush = 1'b0;
    for (int k = 1; k < 100; k++) begin
      if (k == flush_at) flush = 1'b1;
      #1;
      if (done) dones++;
      if (!stallreq) begin
        ended = 1'b1;
        break;
      end
      stalls++;
      if (junk) begin
        op_valid = 1'b1; op = MDU_OP_MTHI; src_a = $urandom;
      end
      @(negedge clk);
      op_valid = 1'b0; op = MDU_OP_NOP; flush = 1'b0;
    end
    if (!ended) check_eq("stall_timeout", 64'd1, 64'd0);
  endtask

  task automatic apply(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int flush_at, input bit junk);
    logic [W-1:0] eh, el;
    logic [63:0]  p;
    longint       sa, sb, q, r;
    longint unsigned ua, ub;
    int es, ed, gs, gd;
    eh = m_hi; el = m_lo; es = 0; ed = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    case (o)
      MDU_OP_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; es = MS + 1; ed = 1; end
      MDU_OP_MULTU: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; es = MS + 1; ed = 1; end
      MDU_OP_DIV: begin
        es = 1;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0]; es = W + 1; ed = 1;
        end
      end
      MDU_OP_DIVU: begin
        es = 1;
        if (b != 0) begin
          p = ua / ub; el = p[31:0];
          p = ua % ub; eh = p[31:0]; es = W + 1; ed = 1;
        end
      end
      MDU_OP_MTHI: eh = a;
      MDU_OP_MTLO: el = a;
      default: ;
    endcase
    if (flush_at >= 0 && ((es == 0) ? (flush_at == 0) : (flush_at < es))) begin
      eh = m_hi; el = m_lo; ed = 0;
      es = (flush_at == 0) ? 0 : flush_at + 1;
    end
    do_op(o, a, b, flush_at, junk, gs, gd);
    check_eq({tag, ".hi"}, 64'(hi_rdata), 64'(eh));
    check_eq({tag, ".lo"}, 64'(lo_rdata), 64'(el));
    check_eq({tag, ".stalls"}, 64'(gs), 64'(es));
    check_eq({tag, ".done"}, 64'(gd), 64'(ed));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    n_vec = 0; n_err = 0; m_hi = '0; m_lo = '0;
    resetn = 1'b0; op_valid = 1'b0; op = MDU_OP_NOP; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset.hi", 64'(hi_rdata), 64'd0);
    check_eq("reset.lo", 64'(lo_rdata), 64'd0);
    check_eq("reset.stallreq", 64'(stallreq), 64'd0);
    check_eq("reset.done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    apply("mthi", MDU_OP_MTHI, 32'h1234_5678, 32'h0, -1, 1'b0);
    apply("mtlo", MDU_OP_MTLO, 32'hDEAD_BEEF, 32'h0, -1, 1'b0);
    apply("mult", MDU_OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
    apply("multu", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
    apply("div_neg", MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    apply("divu", MDU_OP_DIVU, 32'd100, 32'd7, -1, 1'b0);
    apply("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    apply("divu_zero", MDU_OP_DIVU, 32'd5, 32'd0, -1, 1'b0);
    apply("divu_flush", MDU_OP_DIVU, 32'hCAFE_0001, 32'd3, 10, 1'b0);
    apply("mult_after_flush", MDU_OP_MULT, 32'h0001_0003, 32'hFFFF_FFF0, -1, 1'b0);
    apply("mthi_flush", MDU_OP_MTHI, 32'h5555_AAAA, 32'h0, 0, 1'b0);
    apply("mult_flush_accept", MDU_OP_MULT, 32'd9, 32'd9, 0, 1'b0);
    apply("mult_flush_done", MDU_OP_MULTU, 32'd11, 32'd13, MS, 1'b0);
    apply("div_busy_junk", MDU_OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD, -1, 1'b1);
    apply("mult_busy_junk", MDU_OP_MULTU, 32'hABCD_1234, 32'h1357_9BDF, -1, 1'b1);
    apply("bad_op", 3'd7, 32'h1111_1111, 32'h2, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 9));
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      apply("rand", ro, ra, rb, -1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a divide.
    op_valid = 1'b1; op = MDU_OP_DIVU; src_a = 32'hFFFF_0000; src_b = 32'd17;
    @(negedge clk);
    op_valid = 1'b0; op = MDU_OP_NOP;
    repeat (5) @(negedge clk);
    check_eq("pre_reset.stallreq", 64'(stallreq), 64'd1);
    resetn = 1'b0;
    #1;
    check_eq("async_reset.hi", 64'(hi_rdata), 64'd0);
    check_eq("async_reset.lo", 64'(lo_rdata), 64'd0);
    check_eq("async_reset.stallreq", 64'(stallreq), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    apply("post_reset_divu", MDU_OP_DIVU, 32'd1000, 32'd33, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
